switch_repeat_pulser: RTL and testbench
=======================================

# switch_repeat_pulser

Converts a clean, debounced switch level into discrete paddle-step events for the Pong game logic. It sits directly downstream of the switch debouncer, one instance per paddle button. It emits a single-cycle press pulse, then auto-repeat pulses while the button is held, and a release pulse when it is let go. Paddle movement logic consumes `o_STEP` and never inspects the switch level directly.

## Interface
- `c_HOLD_DELAY`, 12500000: cycles from press pulse to first repeat pulse (500 ms @ 25 MHz); legal range 2 .. 2^24-1.
- `c_REPEAT_PERIOD`, 2500000: cycles between successive repeat pulses (100 ms @ 25 MHz); legal range 2 .. 2^24-1.
- `i_CLK`  in  1  system clock, 25 MHz; sole clock.
- `i_RST`  in  1  reset, synchronous, active-high.
- `i_SW`  in  1  debounced switch level, already synchronous to `i_CLK`.
- `o_PRESS`  out  1  one-cycle pulse on accepted press.
- `o_REPEAT`  out  1  one-cycle pulse per auto-repeat.
- `o_STEP`  out  1  `o_PRESS | o_REPEAT` (registered, not combinational).
- `o_RELEASE`  out  1  one-cycle pulse on release of a held button.
- `o_HELD`  out  1  high while state is not IDLE.
- `o_REPEAT_CNT`  out  8  repeats since last press, saturating at 255.

## Operation
- Registers: `rPrev` (last sampled `i_SW`), 24-bit `rCount`, 2-bit state, output flops.
- States:
  - IDLE: waiting for a press.
  - DELAY: counting toward `c_HOLD_DELAY`.
  - REPEAT: counting toward `c_REPEAT_PERIOD`.
- Press edge (`i_SW=1`, `rPrev=0`) in IDLE:
  - Assert `o_PRESS` and `o_STEP`.
  - Clear `rCount` and `o_REPEAT_CNT`.
  - Go to DELAY.
- DELAY, `i_SW=1`:
  - `rCount` increments.
  - When `rCount == c_HOLD_DELAY-1`: assert `o_REPEAT` and `o_STEP`, clear `rCount`, increment `o_REPEAT_CNT`, go to REPEAT.
- REPEAT, `i_SW=1`:
  - Same as DELAY, but the terminal value is `c_REPEAT_PERIOD-1`; state stays in REPEAT.
- DELAY or REPEAT, `i_SW=0`:
  - Assert `o_RELEASE`, clear `rCount`, go to IDLE.
  - `o_REPEAT_CNT` holds its value until the next press.
- Release and count terminal in the same cycle: release wins. No `o_REPEAT`, counter not incremented.
- Falling edge while in IDLE (after reset with switch held): update `rPrev` only; no `o_RELEASE`.
- `o_REPEAT_CNT` increments are saturating: 255 stays at 255.
- `rCount` never exceeds the active terminal value; no wrap-around.

## Timing
- Outputs are all registered; latency is 1 cycle.
  - If edge k is the first edge where the press condition holds, `o_PRESS` is high in the cycle after edge k only.
- First `o_REPEAT` rises at edge k+`c_HOLD_DELAY`.
- Subsequent `o_REPEAT` pulses rise every `c_REPEAT_PERIOD` edges after that.
- `o_RELEASE` rises at the edge that first samples `i_SW=0` in DELAY or REPEAT.
- `o_HELD` rises with `o_PRESS` and falls with `o_RELEASE`.
- Pulses are never longer than 1 cycle. `o_PRESS`, `o_REPEAT` and `o_RELEASE` are mutually exclusive in every cycle.
- Reset, at any point mid-operation, takes effect at the next edge with `i_RST=1`:
  - State becomes IDLE, `rCount=0`.
  - All outputs become 0, including `o_REPEAT_CNT`.
  - `rPrev` is set to 1, so a switch held through reset produces no press until it is released and pressed again.

## Structure
- Shared package `pong_input_pkg` holds:
  - State encoding constants (IDLE=0, DELAY=1, REPEAT=2).
  - Default timing constants `c_HOLD_DELAY_25M` and `c_REPEAT_PERIOD_25M`.
  - Counter width constant (24).
- No sub-module; edge detection, counter and FSM are inline in one module.

## Test plan
Bench uses `c_HOLD_DELAY=10` and `c_REPEAT_PERIOD=4`.
- Tap: `i_SW` high for 3 cycles then low -> `o_PRESS` one pulse one cycle after the rise, no `o_REPEAT`, `o_RELEASE` one pulse, `o_REPEAT_CNT=0`.
- Hold: `i_SW` high for 30 cycles after press edge k -> `o_REPEAT` at k+10, k+14, k+18, k+22, k+26, then `o_REPEAT_CNT=5`. `o_STEP` count = 6.
- Release colliding with a repeat: release sampled at exactly k+10 -> `o_RELEASE` only, no `o_REPEAT`, `o_REPEAT_CNT=0`.
- Reset with switch held: `i_RST` pulse while `i_SW=1` in REPEAT -> all outputs 0; no `o_PRESS` while held; low then high again -> `o_PRESS` once, no `o_RELEASE` on that falling edge.
- Saturation: hold for 10+4*260 cycles -> `o_REPEAT_CNT` stays at 255 and `o_REPEAT` keeps pulsing every 4 cycles.
- Mutual exclusion: random `i_SW` stimulus with `i_SW` changes spaced at least 2 cycles apart, 10k cycles -> `o_PRESS`, `o_REPEAT` and `o_RELEASE` never high together; `o_STEP == o_PRESS|o_REPEAT` every cycle.

Source files
------------

// File: rtl/pong_input_pkg.sv
// Shared definitions for the Pong paddle input path: FSM state encoding,
// default timing at 25 MHz, counter widths and a saturating-increment helper.
package pong_input_pkg;

  localparam int unsigned CNT_W        = 24;
  localparam int unsigned REPEAT_CNT_W = 8;

  // 500 ms and 100 ms at 25 MHz
  localparam int unsigned c_HOLD_DELAY_25M    = 12500000;
  localparam int unsigned c_REPEAT_PERIOD_25M = 2500000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [REPEAT_CNT_W-1:0] sat_inc(input logic [REPEAT_CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + REPEAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/switch_repeat_pulser.sv
// Turns a debounced switch level into paddle-step events: one press pulse,
// auto-repeat pulses while held, and a release pulse when let go.
// Ports:
//   i_CLK        system clock
//   i_RST        synchronous active-high reset
//   i_SW         debounced switch level, synchronous to i_CLK
//   o_PRESS      one-cycle pulse on accepted press
//   o_REPEAT     one-cycle pulse per auto-repeat
//   o_STEP       registered o_PRESS | o_REPEAT
//   o_RELEASE    one-cycle pulse on release of a held button
//   o_HELD       high while the FSM is not idle
//   o_REPEAT_CNT repeats since last press, saturating at 255
module switch_repeat_pulser
  import pong_input_pkg::*;
#(
  parameter int unsigned c_HOLD_DELAY    = c_HOLD_DELAY_25M,
  parameter int unsigned c_REPEAT_PERIOD = c_REPEAT_PERIOD_25M
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_SW,
  output logic                    o_PRESS,
  output logic                    o_REPEAT,
  output logic                    o_STEP,
  output logic                    o_RELEASE,
  output logic                    o_HELD,
  output logic [REPEAT_CNT_W-1:0] o_REPEAT_CNT
);

  localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(c_HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(c_REPEAT_PERIOD - 1);

  state_e                  state_q, state_d;
  logic                    prev_q, prev_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [REPEAT_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic                    press_q, press_d;
  logic                    repeat_q, repeat_d;
  logic                    step_q, step_d;
  logic                    release_q, release_d;
  logic                    held_q, held_d;
  logic [CNT_W-1:0]        term_c;

  // Terminal count depends on whether we wait for the first repeat or the next one
  assign term_c = (state_q == ST_REPEAT) ? REPEAT_TERM : HOLD_TERM;

  // State and output registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      prev_q    <= 1'b1;  // a switch held through reset must be released first
      count_q   <= '0;
      rep_cnt_q <= '0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      count_q   <= count_d;
      rep_cnt_q <= rep_cnt_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
      release_q <= release_d;
      held_q    <= held_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    prev_d    = i_SW;
    count_d   = count_q;
    rep_cnt_d = rep_cnt_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A falling edge here only updates prev; release is reported only when held
        if (i_SW && !prev_q) begin
          press_d   = 1'b1;
          count_d   = '0;
          rep_cnt_d = '0;
          state_d   = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        // Release takes priority over a terminal count in the same cycle
        if (!i_SW) begin
          release_d = 1'b1;
          count_d   = '0;
          state_d   = ST_IDLE;
        end else if (count_q == term_c) begin
          repeat_d  = 1'b1;
          count_d   = '0;
          rep_cnt_d = sat_inc(rep_cnt_q);
          state_d   = ST_REPEAT;
        end else begin
          count_d   = count_q + CNT_W'(1);
        end
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    step_d = press_d | repeat_d;
    held_d = (state_d != ST_IDLE);
  end

  assign o_PRESS      = press_q;
  assign o_REPEAT     = repeat_q;
  assign o_STEP       = step_q;
  assign o_RELEASE    = release_q;
  assign o_HELD       = held_q;
  assign o_REPEAT_CNT = rep_cnt_q;

endmodule

// File: tb/tb_switch_repeat_pulser.sv
// Directed bench for switch_repeat_pulser with hold delay 10 and repeat period 4.
module tb_switch_repeat_pulser;

  localparam int unsigned HOLD = 10;
  localparam int unsigned PER  = 4;

  logic       clk;
  logic       rst;
  logic       sw;
  logic       press, rep, step, rel, held;
  logic [7:0] cnt;

  int checks;
  int errors;
  int cyc;

  switch_repeat_pulser #(
    .c_HOLD_DELAY    (HOLD),
    .c_REPEAT_PERIOD (PER)
  ) dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_SW         (sw),
    .o_PRESS      (press),
    .o_REPEAT     (rep),
    .o_STEP       (step),
    .o_RELEASE    (rel),
    .o_HELD       (held),
    .o_REPEAT_CNT (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle; outputs then reflect that edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({press, rep, step, rel, held} !== 5'b0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got p%b r%b s%b rl%b h%b cnt=%0d, want all 0",
               press, rep, step, rel, held, cnt);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_tap();
    int n_press, n_rep, n_rel;
    n_press = 0; n_rep = 0; n_rel = 0;
    sw = 1'b1;
    tick();
    checks++;
    if (press !== 1'b1 || step !== 1'b1 || held !== 1'b1) begin
      errors++;
      $display("FAIL tap_press: got p%b s%b h%b, want 1 1 1", press, step, held);
    end
    n_press += int'(press);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_press += int'(press); n_rep += int'(rep); n_rel += int'(rel);
    end
    sw = 1'b0;
    tick();
    checks++;
    if (rel !== 1'b1 || held !== 1'b0) begin
      errors++;
      $display("FAIL tap_release: got rel=%b held=%b, want 1 0", rel, held);
    end
    n_rel += int'(rel);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_press += int'(press); n_rep += int'(rep); n_rel += int'(rel);
    end
    checks++;
    if (n_press != 1 || n_rep != 0 || n_rel != 1 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL tap_counts: got press=%0d rep=%0d rel=%0d cnt=%0d, want 1 0 1 0",
               n_press, n_rep, n_rel, cnt);
    end
  endtask

  task automatic test_hold();
    int k, n_step;
    int pos[$];
    int exp_pos[5];
    exp_pos = '{10, 14, 18, 22, 26};
    sw = 1'b1;
    tick();
    k = cyc;
    n_step = int'(step);
    checks++;
    if (press !== 1'b1) begin
      errors++;
      $display("FAIL hold_press: got %b, want 1", press);
    end
    for (int i = 1; i < 30; i++) begin
      tick();
      if (rep === 1'b1) pos.push_back(cyc - k);
      n_step += int'(step);
    end
    checks++;
    if (pos.size() != 5) begin
      errors++;
      $display("FAIL hold_repeat_num: got %0d, want 5", pos.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pos[i] != exp_pos[i]) begin
          errors++;
          $display("FAIL hold_repeat_pos%0d: got k+%0d, want k+%0d", i, pos[i], exp_pos[i]);
        end
      end
    end
    checks++;
    if (n_step != 6 || cnt !== 8'd5) begin
      errors++;
      $display("FAIL hold_counts: got steps=%0d cnt=%0d, want 6 5", n_step, cnt);
    end
    sw = 1'b0;
    tick();
    checks++;
    if (rel !== 1'b1 || held !== 1'b0 || cnt !== 8'd5) begin
      errors++;
      $display("FAIL hold_release: got rel=%b held=%b cnt=%0d, want 1 0 5", rel, held, cnt);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_release_collision();
    int n_rep;
    n_rep = 0;
    sw = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) begin
      tick();
      n_rep += int'(rep);
    end
    sw = 1'b0;
    tick();
    n_rep += int'(rep);
    checks++;
    if (rel !== 1'b1 || rep !== 1'b0 || n_rep != 0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL collision: got rel=%b rep=%b nrep=%0d cnt=%0d, want 1 0 0 0",
               rel, rep, n_rep, cnt);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset_held();
    int n_press, n_rel;
    n_press = 0; n_rel = 0;
    sw = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    checks++;
    if (cnt !== 8'd1 || held !== 1'b1) begin
      errors++;
      $display("FAIL rh_pre: got cnt=%0d held=%b, want 1 1", cnt, held);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({press, rep, step, rel, held} !== 5'b0 || cnt !== 8'd0) begin
      errors++;
      $display("FAIL rh_reset: got p%b r%b s%b rl%b h%b cnt=%0d, want all 0",
               press, rep, step, rel, held, cnt);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_press += int'(press);
      n_rel += int'(rel) + int'(held);
    end
    sw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_rel += int'(rel);
    end
    checks++;
    if (n_press != 0 || n_rel != 0) begin
      errors++;
      $display("FAIL rh_quiet: got press=%0d rel/held=%0d, want 0 0", n_press, n_rel);
    end
    sw = 1'b1;
    tick();
    checks++;
    if (press !== 1'b1 || held !== 1'b1) begin
      errors++;
      $display("FAIL rh_repress: got press=%b held=%b, want 1 1", press, held);
    end
    tick();
    sw = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_saturation();
    logic       exp_rep;
    logic [7:0] exp_cnt;
    int         n_rep, n_bad;
    exp_cnt = 8'd0; n_rep = 0; n_bad = 0;
    sw = 1'b1;
    tick();
    for (int off = 1; off <= 10 + 4 * 260; off++) begin
      tick();
      exp_rep = (off >= 10) && (((off - 10) % 4) == 0);
      if (exp_rep) begin
        n_rep++;
        if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      end
      if (rep !== exp_rep || cnt !== exp_cnt) begin
        n_bad++;
        if (n_bad <= 5)
          $display("FAIL sat_cycle k+%0d: got rep=%b cnt=%0d, want rep=%b cnt=%0d",
                   off, rep, cnt, exp_rep, exp_cnt);
      end
    end
    checks++;
    if (n_bad != 0) errors++;
    checks++;
    if (cnt !== 8'd255 || n_rep != 261) begin
      errors++;
      $display("FAIL sat_final: got cnt=%0d, want 255 (model repeats %0d)", cnt, n_rep);
    end
    sw = 1'b0;
    tick();
    checks++;
    if (rel !== 1'b1 || cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_release: got rel=%b cnt=%0d, want 1 255", rel, cnt);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_random_exclusion();
    int n, left, n_bad;
    n = 0; n_bad = 0; left = 0;
    while (n < 10000) begin
      if (left == 0) begin
        sw   = ~sw;
        left = int'($urandom_range(2, 16));
      end
      tick();
      left--;
      n++;
      if ((int'(press) + int'(rep) + int'(rel)) > 1 || step !== (press | rep)) begin
        n_bad++;
        if (n_bad <= 5)
          $display("FAIL rand_excl cyc %0d: got p%b r%b rl%b s%b, want one-hot-or-zero and s=p|r",
                   cyc, press, rep, rel, step);
      end
    end
    checks++;
    if (n_bad != 0) errors++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    sw     = 1'b0;
    test_reset();
    test_tap();
    test_hold();
    test_release_collision();
    test_reset_held();
    test_saturation();
    test_random_exclusion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
